// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the device:
//   - the clock is held low to inhibit the device, then a start bit is driven;
//   - data bits go out on device clock falling edges, followed by odd parity and the stop bit;
//   - the device ACK is sampled on the eleventh falling edge;
//   - once both lines are idle again, the bus is handed back and the transfer is reported.
// The lines are driven open-drain through active-high pull-low enables.
// Optional build macro PS2_HOST_TX_RETRY_EN: a failed transfer is retried once with
// the same byte before it is reported.
// Handshake: i_valid/o_ready. A byte is taken on a rising i_clk edge where both are
// high. o_ready is high in the idle and done states only, so i_valid while busy is
// ignored. o_done pulses for one cycle per completed transfer. o_err qualifies
// o_done and holds its value until the next accept.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_err,
    output logic       o_busy,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic             err_q, err_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
`ifdef PS2_HOST_TX_RETRY_EN
    logic             retry_q, retry_d;
`endif

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic fall;
    logic finish;
    logic finish_err;

    // Two-flop synchronisers on both PS/2 lines plus the previous clock level for edge detect.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= i_ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= i_ps2_data;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    // State register and all datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            byte_q    <= '0;
            par_q     <= 1'b0;
            err_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            err_q     <= err_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    // Next-state logic: frame sequencing, ACK sampling, timeout and completion.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        par_d      = par_q;
        err_d      = err_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        finish     = 1'b0;
        finish_err = err_q;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d    = retry_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_valid) begin
                    // Accept: latch the byte and its odd parity, then inhibit the device.
                    byte_d    = i_byte;
                    par_d     = ~^i_byte;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    // Drive the start bit while the clock is still held low.
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_START: begin
                // Release the clock; the device now generates the clock.
                clk_oe_d = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
                state_d  = S_SEND;
            end

            S_SEND, S_ACK, S_WAIT_IDLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == TO_LIMIT) begin
                    // Timeout wins over any edge seen in the same cycle.
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (state_q == S_SEND) begin
                    if (fall) begin
                        if (idx_q < 4'd8) begin
                            data_oe_d = ~byte_q[idx_q[2:0]];
                            idx_d     = idx_q + 4'd1;
                        end else if (idx_q == 4'd8) begin
                            data_oe_d = ~par_q;
                            idx_d     = idx_q + 4'd1;
                        end else begin
                            // Stop bit: release the data line.
                            data_oe_d = 1'b0;
                            state_d   = S_ACK;
                        end
                    end
                end else if (state_q == S_ACK) begin
                    if (fall) begin
                        // The device pulls data low to acknowledge.
                        err_d   = data_sync;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    if (clk_sync && data_sync) begin
                        finish     = 1'b1;
                        finish_err = err_q;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            if (finish_err && !retry_q) begin
                // A single silent retry of the same byte.
                retry_d   = 1'b1;
                err_d     = 1'b0;
                cnt_d     = '0;
                clk_oe_d  = 1'b1;
                state_d   = S_INHIBIT;
            end else begin
                err_d   = finish_err;
                state_d = S_DONE;
            end
`else
            err_d   = finish_err;
            state_d = S_DONE;
`endif
        end
    end

    assign o_ready       = (state_q == S_IDLE) || (state_q == S_DONE);
    assign o_busy        = ~o_ready;
    assign o_done        = (state_q == S_DONE);
    assign o_err         = err_q;
    assign o_ps2_clk_oe  = clk_oe_q;
    assign o_ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: testbench for ps2_host_tx.
// A device model on the open-drain lines clocks frames and ACKs, NACKs or stays silent.
// Frame elements seen on clock rising edges are checked against an expected queue.
// Completion reports are checked against a second expected queue.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH      = 40;
    localparam int TO       = 1500;
    localparam int M_ACK    = 0;
    localparam int M_NACK   = 1;
    localparam int M_SILENT = 2;
    localparam int BUDGET   = 3 * TO + 4 * INH + 2000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       i_valid;
    logic [7:0] i_byte;
    logic       o_ready, o_done, o_err, o_busy;
    logic       clk_oe, data_oe;
    logic       dev_clk_pull, dev_data_pull;
    logic       ps2_clk_line, ps2_data_line;

    // Open-drain bus: a line is high unless the host or the device pulls it low.
    assign ps2_clk_line  = ~(clk_oe | dev_clk_pull);
    assign ps2_data_line = ~(data_oe | dev_data_pull);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (i_valid),
        .i_byte        (i_byte),
        .o_ready       (o_ready),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_busy        (o_busy),
        .i_ps2_clk     (ps2_clk_line),
        .i_ps2_data    (ps2_data_line),
        .o_ps2_clk_oe  (clk_oe),
        .o_ps2_data_oe (data_oe)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_cnt = 0;
    logic [0:0] exp_q[$];
    logic [0:0] exp_err_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    endtask

    task automatic check_min(input string name, input int act, input int min_v);
        n_checks++;
        if (act >= min_v) n_pass++;
        else $display("FAIL %s: got %0d, expected at least %0d", name, act, min_v);
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Expected line values at successive clock rises:
    //   - start bit 0;
    //   - data bits 0..7, LSB first;
    //   - odd parity;
    //   - stop bit 1;
    //   - idle-high data at the rise that follows the ACK.
    function automatic void push_frame(input logic [7:0] b, input int n);
        logic [0:0] items[$];
        items.push_back(1'b0);
        for (int i = 0; i < 8; i++) items.push_back(b[i]);
        items.push_back(($countones(b) % 2 == 0) ? 1'b1 : 1'b0);
        items.push_back(1'b1);
        items.push_back(1'b1);
        for (int i = 0; i < n && i < items.size(); i++) exp_q.push_back(items[i]);
    endfunction

    // ---------------- monitors ----------------
    initial begin : line_monitor
        logic       prev;
        logic [0:0] e;
        prev = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (prev === 1'b0 && ps2_clk_line === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_now("frame_extra_edge", $sformatf("clock rise with data=%0b, required no rise", ps2_data_line));
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bit", ps2_data_line, e);
                end
            end
            prev = ps2_clk_line;
        end
    end

    initial begin : done_monitor
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (o_done === 1'b1) begin
                done_cnt++;
                check("done_pulse_width", prev_done, 0);
                if (exp_err_q.size() == 0) fail_now("done_unexpected", "o_done=1, required 0");
                else check("done_err", o_err, exp_err_q.pop_front());
                check("done_ready", o_ready, 1);
                check("done_busy", o_busy, 0);
                check("done_oe_released", {clk_oe, data_oe}, 0);
            end
            prev_done = o_done;
        end
    end

    // ---------------- device model ----------------
    task automatic dev_attempt(input int mode, input int halfp, input int rst_edge);
        int t;
        int low;
        t = 0;
        while (ps2_clk_line !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            fail_now("request_seen", "clock line stayed high, required an inhibit");
            return;
        end
        low = 0;
        while (ps2_clk_line === 1'b0 && low < 5000) begin
            @(negedge clk);
            low++;
        end
        check_min("inhibit_len", low, INH);
        check("request_data_low", ps2_data_line, 0);
        if (mode == M_SILENT) return;
        repeat (8) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            dev_clk_pull = 1'b1;
            for (int k = 0; k < halfp; k++) begin
                if (e == 11 && k == halfp - 2) dev_data_pull = 1'b0;
                @(negedge clk);
            end
            dev_clk_pull = 1'b0;
            repeat (halfp / 2) @(negedge clk);
            if (e == rst_edge) return;
            if (e == 10 && mode == M_ACK) dev_data_pull = 1'b1;
            repeat (halfp - halfp / 2) @(negedge clk);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_txn(input logic [7:0] b, input int mode, input int halfp,
                           input int rst_edge, input bit inject);
        int attempts;
        int items;
        int tr;
        int start_done;
        int d0;
        bit busy_bad;
        bit no_done;
        attempts = 1;
`ifdef PS2_HOST_TX_RETRY_EN
        if (mode != M_ACK) attempts = 2;
`endif
        items = (mode == M_SILENT) ? 1 : 12;
        if (rst_edge != 0) items = 1 + rst_edge;
        for (int a = 0; a < attempts; a++) push_frame(b, items);
        if (rst_edge == 0) exp_err_q.push_back((mode != M_ACK) ? 1'b1 : 1'b0);

        tr = 0;
        while (o_ready !== 1'b1 && tr < 1000) begin
            @(negedge clk);
            tr++;
        end
        if (tr >= 1000) fail_now("ready_wait", "o_ready=0, required 1 before send");
        i_byte  = b;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_byte  = 8'($urandom);
        start_done = done_cnt;
        busy_bad   = 1'b0;
        no_done    = 1'b0;

        fork
            begin : device
                int tt;
                for (int a = 0; a < attempts; a++) dev_attempt(mode, halfp, rst_edge);
                if (mode == M_SILENT) begin
                    tt = 0;
                    while (done_cnt == start_done && tt < BUDGET) begin
                        @(negedge clk);
                        tt++;
                    end
                    check_min("timeout_len", tt, TO);
                end
            end
            begin : injector
                if (inject) begin
                    repeat (INH + 100) @(negedge clk);
                    check("ready_low_while_busy", o_ready, 0);
                    i_byte  = 8'hAA;
                    i_valid = 1'b1;
                    @(negedge clk);
                    i_valid = 1'b0;
                end
            end
            begin : busy_watch
                int tw;
                if (rst_edge == 0) begin
                    tw = 0;
                    while (done_cnt == start_done && tw < BUDGET) begin
                        if (o_done !== 1'b1 && o_busy !== 1'b1) busy_bad = 1'b1;
                        @(negedge clk);
                        tw++;
                    end
                    if (tw >= BUDGET) no_done = 1'b1;
                end
            end
        join

        if (rst_edge == 0) begin
            if (no_done) fail_now("done_wait", $sformatf("no o_done within %0d cycles, required one", BUDGET));
            check("busy_whole_transfer", busy_bad, 0);
            @(negedge clk);
            check("ready_after_done", o_ready, 1);
        end else begin
            d0    = done_cnt;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("rst_clk_oe", clk_oe, 0);
            check("rst_data_oe", data_oe, 0);
            check("rst_ready", o_ready, 1);
            check("rst_busy", o_busy, 0);
            repeat (200) @(negedge clk);
            check("rst_no_done", done_cnt, d0);
        end
        repeat (20) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #(900_000);
        $display("FAIL watchdog: simulation still running at 90000 cycles, required to finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        rst_n         = 1'b0;
        i_valid       = 1'b0;
        i_byte        = 8'h00;
        dev_clk_pull  = 1'b0;
        dev_data_pull = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", o_ready, 1);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_err", o_err, 0);
        check("reset_clk_oe", clk_oe, 0);
        check("reset_data_oe", data_oe, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_txn(8'hED, M_ACK,    12, 0, 1'b0);
        run_txn(8'hF4, M_ACK,    10, 0, 1'b0);
        run_txn(8'h00, M_NACK,   12, 0, 1'b0);
        run_txn(8'hFF, M_SILENT, 12, 0, 1'b0);
        run_txn(8'h00, M_ACK,    12, 4, 1'b0);
        run_txn(8'hF4, M_ACK,    12, 0, 1'b0);
        run_txn(8'hED, M_ACK,    14, 0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            run_txn(8'($urandom_range(0, 255)),
                    ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK,
                    $urandom_range(8, 16), 0, 1'($urandom_range(0, 1)));
        end

        check("frame_queue_drained", exp_q.size(), 0);
        check("done_queue_drained", exp_err_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter, the send side of the keyboard controller's PS/2 link. It carries command bytes to the keyboard, e.g. 0xED set-LEDs and 0xF4 enable.
- Runs on the system clock. It drives the open-drain PS/2 clock and data lines through active-high pull-low enables.
- It samples both lines through 2-flop synchronisers, releases the bus to the existing receiver when finished, and reports ACK or error.

Parameters:
- INHIBIT_CYCLES, 5000, system cycles the clock line is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum system cycles from clock release to the device ACK (15 ms at 50 MHz).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous, active-low reset
- i_valid  in  1  request to send i_byte
- i_byte  in  8  command byte
- o_ready  out  1  high when idle; a byte is accepted only when i_valid and o_ready are both high
- o_done  out  1  one-cycle pulse when a transfer ends
- o_err  out  1  qualifies o_done: 1 = no ACK or timeout; held until the next accept
- o_busy  out  1  high from accept until o_done
- i_ps2_clk  in  1  PS/2 clock line, asynchronous
- i_ps2_data  in  1  PS/2 data line, asynchronous
- o_ps2_clk_oe  out  1  1 = pull the clock line low
- o_ps2_data_oe  out  1  1 = pull the data line low

Behaviour:
- Reset (sampled on the i_clk rising edge while i_rst_n=0):
  - state = IDLE; all counters = 0; both OEs = 0 (lines released).
  - o_ready=1, o_busy=0, o_done=0, o_err=0.
  - The synchroniser flops reset to 1.
  - A reset mid-transfer aborts immediately and generates no o_done.
- Falling-edge detect: synchronised clock was 1 the previous cycle and is 0 now.
- Frame: start bit 0, data bits 0-7 LSB first, odd parity bit (= ~^byte), stop bit 1, then the device ACK (0).
- IDLE:
  - On i_valid: latch the byte and parity; o_ready=0, o_busy=1, o_err=0; go to INHIBIT.
- INHIBIT:
  - clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles.
  - Then go to START.
- START:
  - Set data_oe=1 (start bit) while clk_oe stays 1 for one cycle.
  - Next cycle clk_oe=0, clear the timeout counter, go to SEND with bit index = 0.
- SEND:
  - On each falling edge the line takes the next frame element:
    - edges 1-8: data_oe = ~byte[idx], idx increments;
    - edge 9: data_oe = ~parity;
    - edge 10: data_oe = 0 (stop bit, line released).
  - Then go to ACK.
- ACK:
  - On the next falling edge (edge 11), sample synchronised data.
  - Data 0 means ACK: set err_flag=0 and go to WAIT_IDLE.
  - Data 1 means no ACK: set err_flag=1 and go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until both synchronised lines are 1, then go to DONE.
- DONE:
  - o_done=1 for one cycle; o_err=err_flag; o_ready=1; o_busy=0; return to IDLE.
- Timeout:
  - The counter runs in START, SEND, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: both OEs=0, err_flag=1, go to DONE.
  - Timeout has priority over a falling edge in the same cycle.
- i_valid while busy is ignored; no queuing.
- Line levels while the clock is released are produced by the external pull-ups.
- Counter widths are $clog2 of the larger parameter, plus 1.

Optional Feature:
- Macro PS2_HOST_TX_RETRY_EN.
- When defined: a failed transfer (no ACK or timeout) is restarted once from INHIBIT with the same byte, and no o_done is generated between the attempts. o_done/o_err reflect the second attempt only. A retry_used flag clears on accept.
- When undefined: the first failure reports o_done with o_err=1.

Test Plan:
- Send 0xED, device model clocks at 12.5 kHz and ACKs:
  - clock held low for ≥5000 cycles;
  - data bits observed 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1;
  - then o_done=1 with o_err=0, and o_ready returns to 1.
- Send 0xF4 with ACK:
  - parity bit observed 0;
  - o_busy is high for the whole transfer;
  - o_done is exactly 1 cycle.
- Send 0x00, device leaves data high at edge 11:
  - o_done=1, o_err=1 (with RETRY_EN: a second INHIBIT occurs first and o_err reflects the second attempt).
- Send 0xFF, device never clocks:
  - after TIMEOUT_CYCLES both OEs are 0;
  - o_done=1, o_err=1.
- Assert i_rst_n=0 for 1 cycle after data-bit edge 4:
  - both OEs are 0 on the next cycle;
  - o_ready=1; no o_done.
  - A following 0xF4 transfer completes with o_err=0.
- Pulse i_valid with 0xAA during an active 0xED transfer:
  - ignored; the 0xED bit pattern is unchanged.
